// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, fixed-latency memory between an instruction-fetch
// requester (IF, read-only) and a data-access requester (DA, read/write).
// Each access runs through four steps: grant, issue, latency wait and
// acknowledge. Only one transaction is in flight at a time, so the port
// completes one access every LATENCY+3 cycles.
//
// Optional build macro:
//   MEM_PORT_ARB_RR_EN  defined   : round-robin on simultaneous requests (the
//                                   requester that did not get the previous
//                                   grant wins; the first tie goes to DA).
//                       undefined : fixed priority, DA beats IF.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   LATENCY  cycles from the mem_en cycle to valid mem_rdata (1..15)
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   if_req/if_addr        fetch request and address, held until if_ack
//   if_ack/if_rdata       one-cycle fetch completion, fetch data (held)
//   da_req/da_we/da_addr/da_wdata  data request, held until da_ack
//   da_ack/da_rdata       one-cycle data completion, load data (reads only)
//   mem_en/mem_we         one-cycle issue strobe, write enable
//   mem_addr/mem_wdata    registered address and write data
//   mem_rdata             read data, valid LATENCY cycles after mem_en
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    // data access requester
    input  logic              da_req,
    input  logic              da_we,
    input  logic [ADDR_W-1:0] da_addr,
    input  logic [DATA_W-1:0] da_wdata,
    output logic              da_ack,
    output logic [DATA_W-1:0] da_rdata,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DA = 1'b1
    } owner_t;

    // The wait counter starts at LATENCY-1 in ISSUE and reaches zero in the
    // cycle mem_rdata is valid.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t              state_q;
    owner_t              owner_q;
    logic [3:0]          cnt_q;
    logic                if_ack_q;
    logic                da_ack_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   da_rdata_q;

    // Arbitration decision, only meaningful in IDLE with a request pending.
    logic                grant_da_d;

`ifdef MEM_PORT_ARB_RR_EN
    owner_t              last_grant_q;

    // On a tie DA wins only if IF had the previous grant.
    assign grant_da_d = da_req && !(if_req && last_grant_q == OWN_DA);
`else
    assign grant_da_d = da_req;
`endif

    // NOTE: every register here, including the rdata holding registers, is a
    // plain flop and gets an explicit reset value; nothing is a memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            cnt_q        <= '0;
            if_ack_q     <= 1'b0;
            da_ack_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            da_rdata_q   <= '0;
`ifdef MEM_PORT_ARB_RR_EN
            last_grant_q <= OWN_IF;
`endif
        end else begin
            // NOTE: the strobes are registered, so each is raised on the edge
            // that enters its state (ISSUE for mem_en, RESP for the acks) and
            // this default drops it again one cycle later.
            mem_en_q <= 1'b0;
            if_ack_q <= 1'b0;
            da_ack_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (if_req || da_req) begin
                        mem_en_q <= 1'b1;
                        state_q  <= S_ISSUE;
                        if (grant_da_d) begin
                            owner_q     <= OWN_DA;
                            mem_we_q    <= da_we;
                            mem_addr_q  <= da_addr;
                            mem_wdata_q <= da_wdata;
                        end else begin
                            // Fetches are always reads with zero write data.
                            owner_q     <= OWN_IF;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
`ifdef MEM_PORT_ARB_RR_EN
                        last_grant_q <= grant_da_d ? OWN_DA : OWN_IF;
`endif
                    end
                end

                S_ISSUE: begin
                    cnt_q   <= CNT_LOAD;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            // Stores complete with an ack but keep the last load data.
                            if (!mem_we_q) begin
                                da_rdata_q <= mem_rdata;
                            end
                            da_ack_q <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                S_RESP: begin
                    // Requests are not looked at here; the next grant is taken in IDLE.
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign da_ack    = da_ack_q;
    assign if_rdata  = if_rdata_q;
    assign da_rdata  = da_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives the arbiter with directed and random IF/DA traffic and a memory
// model that answers reads exactly LATENCY cycles after mem_en. A
// transaction-level reference predicts, per cycle, when each grant, issue and
// ack happens (grant cycle g: issue g+1, ack g+2+LATENCY, next grant no
// earlier than g+3+LATENCY) and what the data registers must hold.
// Build with +define+MEM_PORT_ARB_RR_EN to check round-robin arbitration.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter #(
    parameter int LATENCY = 2
);
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              da_req = 1'b0;
    logic              da_we = 1'b0;
    logic [ADDR_W-1:0] da_addr = '0;
    logic [DATA_W-1:0] da_wdata = '0;
    logic              da_ack;
    logic [DATA_W-1:0] da_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .da_req   (da_req),
        .da_we    (da_we),
        .da_addr  (da_addr),
        .da_wdata (da_wdata),
        .da_ack   (da_ack),
        .da_rdata (da_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // ---------------- memory contents (model image and environment image) ----
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] env_mem   [logic [31:0]];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : mem_default(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        model_mem[a] = d;
        env_mem[a]   = d;
    endtask

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;
    resp_t rq[$];

    // ---------------- reference model state ----------------
    bit          m_active;
    int          m_gcyc;
    bit          m_own_da;
    bit          m_we;
    logic [31:0] m_rd_exp;
    int          m_free;
`ifdef MEM_PORT_ARB_RR_EN
    bit          m_last_da;
`endif
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_da_rdata;
    bit          e_we;

    // ---------------- requester state and directed script ----------------
    bit          if_pend, if_gnt, da_pend, da_gnt;
    bit          if_again, da_again;
    bit          rand_en = 1'b0;
    bit          rereq   = 1'b0;
    bit          if_go, da_go, da_go_we;
    logic [31:0] if_go_addr, da_go_addr, da_go_wdata;
    int          if_start_cyc, da_start_cyc;

    // ---------------- observations ----------------
    int          if_ack_n, da_ack_n;
    int          last_if_ack_cyc, last_da_ack_cyc, last_en_cyc;
    logic [31:0] en_addr, en_wdata;
    logic        en_we;
    bit          ack_log[$];   // 1 = DA, 0 = IF, in completion order

    function automatic logic [31:0] rand_addr();
        return {24'h0, 4'($urandom_range(0, 15)), 4'h0};
    endfunction

    task automatic start_if(input logic [31:0] a);
        if_pend = 1'b1; if_gnt = 1'b0;
        if_req = 1'b1; if_addr = a;
        if_start_cyc = cyc;
    endtask

    task automatic start_da(input bit we, input logic [31:0] a, input logic [31:0] d);
        da_pend = 1'b1; da_gnt = 1'b0;
        da_req = 1'b1; da_we = we; da_addr = a; da_wdata = d;
        da_start_cyc = cyc;
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_free = 0;
`ifdef MEM_PORT_ARB_RR_EN
        m_last_da = 1'b0;
`endif
        e_addr = '0; e_wdata = '0; e_we = 1'b0; e_if_rdata = '0; e_da_rdata = '0;
        if_pend = 0; if_gnt = 0; da_pend = 0; da_gnt = 0; if_again = 0; da_again = 0;
        if_req = 1'b0; da_req = 1'b0;
        rq.delete();
        if_ack_n = 0; da_ack_n = 0;
        last_if_ack_cyc = -1; last_da_ack_cyc = -1; last_en_cyc = -1;
        ack_log.delete();
    endtask

    // Grant decision for the current cycle, from the requests now on the pins.
    task automatic model_grant();
        bit pick_da;
        if (rst || cyc < m_free || !(if_req || da_req)) return;
`ifdef MEM_PORT_ARB_RR_EN
        pick_da = (if_req && da_req) ? !m_last_da : da_req;
        m_last_da = pick_da;
`else
        pick_da = da_req;
`endif
        m_active = 1'b1; m_gcyc = cyc; m_own_da = pick_da; m_free = cyc + 3 + LATENCY;
        if (pick_da) begin
            m_we = da_we; e_we = da_we; e_addr = da_addr; e_wdata = da_wdata; da_gnt = 1'b1;
            if (da_we) model_mem[da_addr] = da_wdata;
            else       m_rd_exp = model_read(da_addr);
        end else begin
            m_we = 1'b0; e_we = 1'b0; e_addr = if_addr; e_wdata = '0; if_gnt = 1'b1;
            m_rd_exp = model_read(if_addr);
        end
    endtask

    task automatic drive_requesters(input bit ia, input bit dk);
        if (ia) begin
            if_pend = 0; if_gnt = 0; if_req = 1'b0; if_again = rereq;
        end else if (!if_pend) begin
            if (if_go) begin
                if_go = 0; start_if(if_go_addr);
            end else if (if_again || (rand_en && $urandom_range(0, 3) == 0)) begin
                if_again = 0; start_if(rand_addr());
            end
        end else if (!if_gnt && rand_en && $urandom_range(0, 15) == 0) begin
            if_pend = 0; if_req = 1'b0; if_addr = $urandom;   // withdrawn before grant
        end

        if (dk) begin
            da_pend = 0; da_gnt = 0; da_req = 1'b0; da_again = rereq;
        end else if (!da_pend) begin
            if (da_go) begin
                da_go = 0; start_da(da_go_we, da_go_addr, da_go_wdata);
            end else if (da_again || (rand_en && $urandom_range(0, 3) == 0)) begin
                da_again = 0; start_da(1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
        end else if (!da_gnt && rand_en && $urandom_range(0, 15) == 0) begin
            da_pend = 0; da_req = 1'b0; da_addr = $urandom;
        end
    endtask

    task automatic memory_env();
        resp_t r;
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            else        rq.push_back('{cyc + LATENCY, env_read(mem_addr)});
        end
        while (rq.size() > 0 && rq[0].due < cyc) rq.delete(0);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            mem_rdata = r.data;
        end else begin
            mem_rdata = $urandom;
        end
    endtask

    // One clock cycle: compare, observe, answer memory, drive requests, decide grant.
    task automatic step();
        bit x_en, x_ia, x_da;
        @(posedge clk);
        #1;
        cyc++;
        x_en = 1'b0; x_ia = 1'b0; x_da = 1'b0;
        if (m_active) begin
            if (cyc == m_gcyc + 1) x_en = 1'b1;
            if (cyc == m_gcyc + 2 + LATENCY) begin
                if (m_own_da) begin
                    x_da = 1'b1;
                    if (!m_we) e_da_rdata = m_rd_exp;
                end else begin
                    x_ia = 1'b1;
                    e_if_rdata = m_rd_exp;
                end
            end
        end
        check("mem_en",    mem_en,    x_en);
        check("mem_we",    mem_we,    e_we);
        check("mem_addr",  mem_addr,  e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("if_ack",    if_ack,    x_ia);
        check("da_ack",    da_ack,    x_da);
        check("if_rdata",  if_rdata,  e_if_rdata);
        check("da_rdata",  da_rdata,  e_da_rdata);

        if (if_ack) begin if_ack_n++; last_if_ack_cyc = cyc; ack_log.push_back(1'b0); end
        if (da_ack) begin da_ack_n++; last_da_ack_cyc = cyc; ack_log.push_back(1'b1); end
        if (mem_en) begin
            last_en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
        end

        memory_env();
        drive_requesters(x_ia, x_da);
        model_grant();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Reset pulse in the middle of a cycle; outputs must clear without a clock edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_if_ack",    if_ack,    0);
        check("rst_da_ack",    da_ack,    0);
        check("rst_mem_en",    mem_en,    0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_da_rdata",  da_rdata,  0);
        model_reset();
        step();
        #2 rst = 1'b0;
        model_grant();
    endtask

    int t;

    initial begin
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        pulse_reset();

        // ---- simultaneous requests straight out of reset: DA first ----
        if_go = 1; if_go_addr = 32'h3000_0000;
        da_go = 1; da_go_we = 0; da_go_addr = 32'h0000_0400; da_go_wdata = '0;
        run(1);
        t = da_start_cyc;
        run(2 * (LATENCY + 3) + 2);
        check("tie_da_ack_cyc", last_da_ack_cyc, t + 2 + LATENCY);
        check("tie_if_en_cyc",  last_en_cyc,     t + 4 + LATENCY);
        check("tie_if_ack_cyc", last_if_ack_cyc, t + 2 * LATENCY + 5);
        check("tie_first_is_da", ack_log[0], 1);
        check("tie_second_is_if", ack_log[1], 0);

        // ---- both requesters re-request immediately after every ack ----
        run(1);
        pulse_reset();
        rereq = 1'b1;
        if_go = 1; if_go_addr = 32'h0000_0010;
        da_go = 1; da_go_we = 0; da_go_addr = 32'h0000_0020; da_go_wdata = '0;
        run(4 * (LATENCY + 3) + 2);
        rereq = 1'b0;
        run(3 * (LATENCY + 3) + 2);
        check("b2b_ack_count", ack_log.size() >= 4, 1);
`ifdef MEM_PORT_ARB_RR_EN
        check("b2b_grant0", ack_log[0], 1);
        check("b2b_grant1", ack_log[1], 0);
        check("b2b_grant2", ack_log[2], 1);
        check("b2b_grant3", ack_log[3], 0);
`else
        check("b2b_grant0", ack_log[0], 1);
        check("b2b_grant1", ack_log[1], 1);
        check("b2b_grant2", ack_log[2], 1);
        check("b2b_grant3", ack_log[3], 1);
`endif

        // ---- single IF read ----
        run(1);
        pulse_reset();
        preload(32'h8000_0000, 32'h0000_0013);
        if_go = 1; if_go_addr = 32'h8000_0000;
        run(1);
        t = if_start_cyc;
        run(LATENCY + 4);
        check("ifrd_en_cyc",   last_en_cyc,     t + 1);
        check("ifrd_en_addr",  en_addr,         32'h8000_0000);
        check("ifrd_en_we",    en_we,           0);
        check("ifrd_ack_cyc",  last_if_ack_cyc, t + 2 + LATENCY);
        check("ifrd_ack_cnt",  if_ack_n,        1);
        check("ifrd_rdata",    if_rdata,        32'h0000_0013);

        // ---- DA write ----
        da_go = 1; da_go_we = 1; da_go_addr = 32'h0000_0100; da_go_wdata = 32'hDEAD_BEEF;
        run(1);
        t = da_start_cyc;
        run(LATENCY + 4);
        check("dawr_en_we",    en_we,           1);
        check("dawr_en_addr",  en_addr,         32'h0000_0100);
        check("dawr_en_wdata", en_wdata,        32'hDEAD_BEEF);
        check("dawr_ack_cyc",  last_da_ack_cyc, t + 2 + LATENCY);
        check("dawr_rdata",    da_rdata,        32'h0000_0000);

        // ---- DA read then IF read: each rdata register keeps its own value ----
        preload(32'h0000_0200, 32'h1234_5678);
        preload(32'h8000_0004, 32'hAAAA_AAAA);
        da_go = 1; da_go_we = 0; da_go_addr = 32'h0000_0200; da_go_wdata = 32'h5555_5555;
        run(LATENCY + 5);
        if_go = 1; if_go_addr = 32'h8000_0004;
        run(LATENCY + 5);
        check("mix_da_rdata", da_rdata, 32'h1234_5678);
        check("mix_if_rdata", if_rdata, 32'hAAAA_AAAA);

        // ---- reset during the WAIT of a DA read ----
        da_go = 1; da_go_we = 0; da_go_addr = 32'h0000_0200; da_go_wdata = '0;
        run(3);      // start cycle, ISSUE, first WAIT cycle
        pulse_reset();
        run(LATENCY + 4);
        check("rstwait_no_da_ack", da_ack_n, 0);
        if_go = 1; if_go_addr = 32'h8000_0000;
        run(1);
        t = if_start_cyc;
        run(LATENCY + 4);
        check("rstwait_if_ack_cyc", last_if_ack_cyc, t + 2 + LATENCY);
        check("rstwait_if_rdata",   if_rdata,        32'h0000_0013);

        // ---- random traffic against the reference ----
        run(1);
        pulse_reset();
        rand_en = 1'b1;
        run(3000);
        rand_en = 1'b0;
        run(3 * (LATENCY + 3) + 4);
        check("rand_if_idle", if_pend, 0);
        check("rand_da_idle", da_pend, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
